// File: rtl/core_pkg.sv
// Shared definitions for the core instruction interface and the program issuer.
package core_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

   typedef logic [3:0] opcode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      LOADED = 2'd2,
      RUN    = 2'd3
   } issuer_state_t;

   // Opcode lives in the top nibble of every instruction word.
   function automatic opcode_t instr_opcode(input logic [INSTR_W-1:0] word);
      return word[INSTR_W-1:INSTR_W-4];
   endfunction

endpackage

// File: rtl/instr_issuer_if.sv
// Host load port plus core instruction port of the issuer.
// Carries loop_count only when ISSUER_LOOP_EN is defined.
interface instr_issuer_if
   import core_pkg::*;
#(
   parameter int unsigned DEPTH = 32
);
   localparam int unsigned LEN_W = $clog2(DEPTH + 1);

   logic               load_valid;
   logic [INSTR_W-1:0] load_instr;
   logic               load_last;
   logic               load_ready;
   logic               start;
   logic               hold;
`ifdef ISSUER_LOOP_EN
   logic [7:0]         loop_count;
`endif
   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic               busy;
   logic               done;
   logic [LEN_W-1:0]   prog_len;

   modport master (
      output load_valid, load_instr, load_last, start, hold,
`ifdef ISSUER_LOOP_EN
      output loop_count,
`endif
      input  load_ready, instr_valid, instr, busy, done, prog_len
   );

   modport slave (
      input  load_valid, load_instr, load_last, start, hold,
`ifdef ISSUER_LOOP_EN
      input  loop_count,
`endif
      output load_ready, instr_valid, instr, busy, done, prog_len
   );

endinterface

// File: rtl/issuer_prog_mem.sv
// Program store: synchronous write, asynchronous read.
module issuer_prog_mem
   import core_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic               clock,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_issuer.sv
// Program buffer and sequencer feeding the core's instruction port.
// ISSUER_LOOP_EN adds loop_count: the program repeats loop_count+1 times.
module instr_issuer
   import core_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned LEN_W = $clog2(DEPTH + 1)
) (
   input  logic           clock,
   input  logic           reset,
   instr_issuer_if.slave  bus
);

   localparam int unsigned AW = $clog2(DEPTH);

   issuer_state_t      state_q, state_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [LEN_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LEN_W-1:0]   prog_len_q, prog_len_d;
   logic               instr_valid_q, instr_valid_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               load_ready_q, load_ready_d;
`ifdef ISSUER_LOOP_EN
   logic [7:0]         loop_q, loop_d;
   logic [7:0]         loops_left;
`endif

   logic               beat;
   logic               issue;
   logic [LEN_W-1:0]   rd_next;
   logic               mem_we;
   logic [AW-1:0]      mem_waddr;
   logic [AW-1:0]      mem_raddr;
   logic [INSTR_W-1:0] mem_rdata;

   issuer_prog_mem #(.DEPTH(DEPTH)) u_mem (
      .clock (clock),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (bus.load_instr),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      prog_len_d    = prog_len_q;
      instr_valid_d = 1'b0;
      instr_d       = NOP_INSTR;
      done_d        = 1'b0;
      mem_we        = 1'b0;
      mem_waddr     = wr_ptr_q;
      mem_raddr     = rd_ptr_q[AW-1:0];
      issue         = 1'b0;
      rd_next       = '0;
`ifdef ISSUER_LOOP_EN
      loop_d        = loop_q;
      loops_left    = (state_q == RUN) ? loop_q : bus.loop_count;
`endif
      beat          = bus.load_valid && load_ready_q;

      case (state_q)
         IDLE, LOADED: begin
            if (beat) begin
               // A new first word always restarts the program at slot 0.
               mem_we     = 1'b1;
               mem_waddr  = '0;
               wr_ptr_d   = AW'(1);
               prog_len_d = LEN_W'(1);
               state_d    = bus.load_last ? LOADED : LOAD;
            end else if (state_q == LOADED && bus.start) begin
               // The start cycle already issues word 0 so it lands one cycle later.
               state_d   = RUN;
               rd_ptr_d  = '0;
               mem_raddr = '0;
               issue     = !bus.hold;
`ifdef ISSUER_LOOP_EN
               loop_d    = bus.loop_count;
`endif
            end
         end
         LOAD: begin
            if (beat) begin
               mem_we     = 1'b1;
               wr_ptr_d   = wr_ptr_q + AW'(1);
               prog_len_d = prog_len_q + LEN_W'(1);
               if (bus.load_last || wr_ptr_q == AW'(DEPTH - 1)) state_d = LOADED;
            end
         end
         RUN: begin
            if (rd_ptr_q == prog_len_q) begin
               state_d = LOADED;
               done_d  = 1'b1;
            end else begin
               issue = !bus.hold;
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         instr_valid_d = 1'b1;
         instr_d       = mem_rdata;
         rd_next       = LEN_W'(mem_raddr) + LEN_W'(1);
         rd_ptr_d      = rd_next;
`ifdef ISSUER_LOOP_EN
         // Wrap straight back to word 0 while passes remain, no bubble.
         if (rd_next == prog_len_q && loops_left != 8'd0) begin
            rd_ptr_d = '0;
            loop_d   = loops_left - 8'd1;
         end
`endif
      end

      busy_d       = (state_d == RUN);
      load_ready_d = (state_d != RUN);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         prog_len_q    <= '0;
         instr_valid_q <= 1'b0;
         instr_q       <= NOP_INSTR;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         load_ready_q  <= 1'b1;
`ifdef ISSUER_LOOP_EN
         loop_q        <= 8'd0;
`endif
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         prog_len_q    <= prog_len_d;
         instr_valid_q <= instr_valid_d;
         instr_q       <= instr_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         load_ready_q  <= load_ready_d;
`ifdef ISSUER_LOOP_EN
         loop_q        <= loop_d;
`endif
      end
   end

   assign bus.load_ready  = load_ready_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.instr       = instr_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.prog_len    = prog_len_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Scoreboard bench for instr_issuer: each driven cycle queues the outputs expected next cycle.
module tb_instr_issuer;
   import core_pkg::*;

   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic        v;
      logic [15:0] i;
      logic        d;
      logic        b;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   always #5 clock = ~clock;

   instr_issuer_if #(.DEPTH(DEPTH)) bus ();

   instr_issuer #(.DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Advance one clock; compare outputs against the oldest queued expectation.
   task automatic tick();
      exp_t e;
      @(posedge clock);
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check_eq("instr_valid", 32'(bus.instr_valid), 32'(e.v));
         check_eq("instr",       32'(bus.instr),       32'(e.i));
         check_eq("done",        32'(bus.done),        32'(e.d));
         check_eq("busy",        32'(bus.busy),        32'(e.b));
      end
   endtask

   task automatic drive(input logic st, input logic hd, input logic ev,
                        input logic [15:0] ei, input logic ed, input logic eb);
      exp_t e;
      bus.start = st;
      bus.hold  = hd;
      e.v = ev; e.i = ei; e.d = ed; e.b = eb;
      sb.push_back(e);
      tick();
      bus.start = 1'b0;
      bus.hold  = 1'b0;
   endtask

   task automatic load_word(input logic [15:0] w, input logic last);
      bus.load_valid = 1'b1;
      bus.load_instr = w;
      bus.load_last  = last;
      check_eq("load_ready_beat", 32'(bus.load_ready), 32'd1);
      tick();
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      bus.load_valid = 1'b0;
      bus.load_instr = 16'h0000;
      bus.load_last  = 1'b0;
      bus.start      = 1'b0;
      bus.hold       = 1'b0;
`ifdef ISSUER_LOOP_EN
      bus.loop_count = 8'd0;
`endif
      tick();
      tick();
      reset = 1'b0;
      check_eq("rst_valid",      32'(bus.instr_valid), 32'd0);
      check_eq("rst_instr",      32'(bus.instr),       32'd0);
      check_eq("rst_busy",       32'(bus.busy),        32'd0);
      check_eq("rst_done",       32'(bus.done),        32'd0);
      check_eq("rst_load_ready", 32'(bus.load_ready),  32'd1);
      check_eq("rst_prog_len",   32'(bus.prog_len),    32'd0);

      // start with no program is ignored
      drive(1, 0, 0, 16'h0000, 0, 0);
      drive(0, 0, 0, 16'h0000, 0, 0);

      // basic two-word program
      load_word(16'h911e, 0);
      load_word(16'h9201, 1);
      check_eq("len2", 32'(bus.prog_len), 32'd2);
      drive(1, 0, 1, 16'h911e, 0, 1);
      drive(0, 0, 1, 16'h9201, 0, 1);
      drive(0, 0, 0, 16'h0000, 1, 0);
      drive(0, 0, 0, 16'h0000, 0, 0);

      // hold in the start cycle delays everything by one
      drive(1, 1, 0, 16'h0000, 0, 1);
      drive(0, 0, 1, 16'h911e, 0, 1);
      drive(0, 0, 1, 16'h9201, 0, 1);
      drive(0, 0, 0, 16'h0000, 1, 0);
      drive(0, 0, 0, 16'h0000, 0, 0);

      // start and load offers during RUN are ignored
      drive(1, 0, 1, 16'h911e, 0, 1);
      bus.load_valid = 1'b1;
      bus.load_instr = 16'hbeef;
      bus.load_last  = 1'b1;
      check_eq("run_load_ready", 32'(bus.load_ready), 32'd0);
      drive(1, 0, 1, 16'h9201, 0, 1);
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      drive(1, 0, 0, 16'h0000, 1, 0);
      drive(0, 0, 0, 16'h0000, 0, 0);
      check_eq("run_len_kept", 32'(bus.prog_len), 32'd2);
      drive(1, 0, 1, 16'h911e, 0, 1);
      drive(0, 0, 1, 16'h9201, 0, 1);
      drive(0, 0, 0, 16'h0000, 1, 0);

      // three words, hold toggling, hold on the last word delays done
      load_word(16'h3001, 0);
      load_word(16'h4002, 0);
      load_word(16'h5003, 1);
      check_eq("len3", 32'(bus.prog_len), 32'd3);
      drive(1, 0, 1, 16'h3001, 0, 1);
      drive(0, 1, 0, 16'h0000, 0, 1);
      drive(0, 0, 1, 16'h4002, 0, 1);
      drive(0, 1, 0, 16'h0000, 0, 1);
      drive(0, 0, 1, 16'h5003, 0, 1);
      drive(0, 0, 0, 16'h0000, 1, 0);
      drive(0, 0, 0, 16'h0000, 0, 0);

      // reset during RUN invalidates the program
      drive(1, 0, 1, 16'h3001, 0, 1);
      reset = 1'b1;
      drive(0, 0, 0, 16'h0000, 0, 0);
      reset = 1'b0;
      check_eq("midrst_len",        32'(bus.prog_len),   32'd0);
      check_eq("midrst_load_ready", 32'(bus.load_ready), 32'd1);
      drive(1, 0, 0, 16'h0000, 0, 0);
      drive(0, 0, 0, 16'h0000, 0, 0);

      // fill all slots without load_last: truncates to DEPTH
      load_word(16'h1111, 0);
      load_word(16'h2222, 0);
      load_word(16'h3333, 0);
      load_word(16'h4444, 0);
      check_eq("full_len",        32'(bus.prog_len),   32'(DEPTH));
      check_eq("full_load_ready", 32'(bus.load_ready), 32'd1);
      drive(1, 0, 1, 16'h1111, 0, 1);
      drive(0, 0, 1, 16'h2222, 0, 1);
      drive(0, 0, 1, 16'h3333, 0, 1);
      drive(0, 0, 1, 16'h4444, 0, 1);
      drive(0, 0, 0, 16'h0000, 1, 0);
      // fifth beat restarts the program at slot 0
      load_word(16'h5555, 0);
      check_eq("restart_len", 32'(bus.prog_len), 32'd1);
      load_word(16'h6666, 1);
      check_eq("restart_len2", 32'(bus.prog_len), 32'd2);
      drive(1, 0, 1, 16'h5555, 0, 1);
      drive(0, 0, 1, 16'h6666, 0, 1);
      drive(0, 0, 0, 16'h0000, 1, 0);
      drive(0, 0, 0, 16'h0000, 0, 0);

`ifdef ISSUER_LOOP_EN
      // three back-to-back passes, loop_count latched at start
      load_word(16'h911e, 0);
      load_word(16'h9201, 1);
      bus.loop_count = 8'd2;
      drive(1, 0, 1, 16'h911e, 0, 1);
      bus.loop_count = 8'd0;
      drive(0, 0, 1, 16'h9201, 0, 1);
      drive(0, 0, 1, 16'h911e, 0, 1);
      drive(0, 0, 1, 16'h9201, 0, 1);
      drive(0, 0, 1, 16'h911e, 0, 1);
      drive(0, 0, 1, 16'h9201, 0, 1);
      drive(0, 0, 0, 16'h0000, 1, 0);
      drive(0, 0, 0, 16'h0000, 0, 0);
      // hold exactly at the wrap point
      bus.loop_count = 8'd1;
      drive(1, 0, 1, 16'h911e, 0, 1);
      drive(0, 0, 1, 16'h9201, 0, 1);
      drive(0, 1, 0, 16'h0000, 0, 1);
      drive(0, 0, 1, 16'h911e, 0, 1);
      drive(0, 0, 1, 16'h9201, 0, 1);
      drive(0, 0, 0, 16'h0000, 1, 0);
      drive(0, 0, 0, 16'h0000, 0, 0);
`endif

      check_eq("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
